// File: rtl/spi_slave.sv
// SPI slave endpoint (SS active-low, LSB first, MOSI sampled on SCLK rise, MISO
// updated on SCLK fall). All SPI pins are oversampled in the clk domain.
module spi_slave #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] IDLE_WORD   = 32'hF0F0F0F0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_write,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_pending,
  input  logic              rx_ack,
  output logic              rx_overrun,
  output logic              frame_err,
  output logic              busy,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_last_q, sclk_last_d;
  logic                   ss_last_q, ss_last_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic                   armed_q, armed_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]      rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_pending_q, rx_pending_d;
  logic                   rx_overrun_q, rx_overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic                   miso_q, miso_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, settled;
  logic [DATA_W-1:0] tx_load_word;

  // Synchronizers and edge detection.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_last_d = sclk_s;
    ss_last_d   = ss_s;
    sclk_rise   = sclk_s & ~sclk_last_q;
    sclk_fall   = ~sclk_s & sclk_last_q;
    ss_rise     = ss_s & ~ss_last_q;
    // A frame may only start once ss has been seen high after the chain has
    // flushed its reset value, so ss held low through reset never starts one.
    settled     = (settle_q == SET_W'(SYNC_STAGES + 1));
    settle_d    = settled ? settle_q : settle_q + SET_W'(1);
    armed_d     = armed_q | (settled & ss_s & ss_last_q);
    ss_fall     = ~ss_s & ss_last_q & armed_q;
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    rx_data_d    = rx_data_q;
    rx_pending_d = rx_pending_q;
    rx_overrun_d = rx_overrun_q;
    frame_err_d  = 1'b0;
    busy_d       = busy_q;
    miso_d       = miso_q;
    tx_load_word = hold_full_q ? hold_q : IDLE_WORD;

    if (rx_ack) begin
      rx_pending_d = 1'b0;
      rx_overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_sh_d     = tx_load_word;
          miso_d      = tx_load_word[0];
          hold_full_d = 1'b0;
          cnt_d       = '0;
          rx_sh_d     = '0;
          busy_d      = 1'b1;
          state_d     = SHIFT;
        end else if (ss_rise) begin
          busy_d = 1'b0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          frame_err_d = 1'b1;
          rx_sh_d     = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_sh_d = {mosi_s, rx_sh_q[DATA_W-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_W'(DATA_W)) state_d = DONE;
          end
          if (sclk_fall) begin
            tx_sh_d = tx_sh_q >> 1;
            miso_d  = tx_sh_q[1];
          end
        end
      end
      DONE: begin
        rx_data_d    = rx_sh_q;
        rx_pending_d = 1'b1;
        // An ack landing on the completion cycle clears the old overrun but
        // the new word still becomes pending.
        rx_overrun_d = rx_ack ? 1'b0 : (rx_overrun_q | rx_pending_q);
        if (ss_rise) busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Applied after the frame-start load so a coincident write stays held.
    if (tx_write) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q  <= '0;
      ss_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_last_q  <= 1'b0;
      ss_last_q    <= 1'b1;
      settle_q     <= '0;
      armed_q      <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_pending_q <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      ss_sync_q    <= ss_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_last_q  <= sclk_last_d;
      ss_last_q    <= ss_last_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      rx_data_q    <= rx_data_d;
      rx_pending_q <= rx_pending_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      miso_q       <= miso_d;
    end
  end

  assign tx_ready   = ~hold_full_q;
  assign rx_data    = rx_data_q;
  assign rx_pending = rx_pending_q;
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign miso       = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a table of full frames plus hand-written
// sequences for aborted frames, writes during a frame and reset mid-frame.
module tb_spi_slave;

  localparam int HALF = 6;  // clk cycles per sclk half period

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tx_data;
  logic        tx_write;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_pending;
  logic        rx_ack;
  logic        rx_overrun;
  logic        frame_err;
  logic        busy;
  logic        sclk;
  logic        ss;
  logic        mosi;
  logic        miso;

  always #5 clk = ~clk;

  spi_slave #(
    .DATA_W     (32),
    .IDLE_WORD  (32'hF0F0F0F0),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .tx_data   (tx_data),
    .tx_write  (tx_write),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_pending(rx_pending),
    .rx_ack    (rx_ack),
    .rx_overrun(rx_overrun),
    .frame_err (frame_err),
    .busy      (busy),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso)
  );

  typedef struct {
    bit          load;
    logic [31:0] tx_word;
    logic [31:0] mo;
    logic [31:0] exp_miso;
    logic [31:0] exp_rx;
    bit          exp_pend;
    bit          exp_ovr;
    bit          ack;
  } vec_t;

  vec_t        vecs[3];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_pulses = 0;
  int          e0;
  logic [31:0] m_rx;

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_low();
    m_rx = '0;
    ss   = 1'b0;
    clk_wait(HALF);
  endtask

  task automatic xfer_bits(input logic [31:0] mo, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      mosi = mo[i];
      clk_wait(HALF);
      sclk = 1'b1;
      clk_wait(HALF);
      sclk = 1'b0;
      m_rx[i] = miso;
    end
  endtask

  task automatic ss_high();
    mosi = 1'b0;
    ss   = 1'b1;
    clk_wait(2 * HALF);
  endtask

  task automatic write_tx(input logic [31:0] w);
    tx_data  = w;
    tx_write = 1'b1;
    clk_wait(1);
    tx_write = 1'b0;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    clk_wait(1);
    rx_ack = 1'b0;
    clk_wait(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " tx_ready"},   32'(tx_ready),   32'd1);
    check({tag, " rx_data"},    rx_data,         32'h0);
    check({tag, " rx_pending"}, 32'(rx_pending), 32'd0);
    check({tag, " rx_overrun"}, 32'(rx_overrun), 32'd0);
    check({tag, " frame_err"},  32'(frame_err),  32'd0);
    check({tag, " busy"},       32'(busy),       32'd0);
    check({tag, " miso"},       32'(miso),       32'd0);
  endtask

  initial begin
    vecs[0] = '{load: 1'b0, tx_word: 32'h0, mo: 32'h0000_0001, exp_miso: 32'hF0F0_F0F0,
                exp_rx: 32'h0000_0001, exp_pend: 1'b1, exp_ovr: 1'b0, ack: 1'b0};
    vecs[1] = '{load: 1'b0, tx_word: 32'h0, mo: 32'h0000_0002, exp_miso: 32'hF0F0_F0F0,
                exp_rx: 32'h0000_0002, exp_pend: 1'b1, exp_ovr: 1'b1, ack: 1'b1};
    vecs[2] = '{load: 1'b1, tx_word: 32'hA5C3_0F81, mo: 32'h1234_5678, exp_miso: 32'hA5C3_0F81,
                exp_rx: 32'h1234_5678, exp_pend: 1'b1, exp_ovr: 1'b0, ack: 1'b0};

    rst_n = 1'b0; tx_data = '0; tx_write = 1'b0; rx_ack = 1'b0;
    sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    clk_wait(3);
    check_reset_values("reset");
    rst_n = 1'b1;
    clk_wait(10);

    // Table of complete frames.
    for (int v = 0; v < 3; v++) begin
      if (vecs[v].load) begin
        write_tx(vecs[v].tx_word);
        check($sformatf("v%0d tx_ready after write", v), 32'(tx_ready), 32'd0);
      end
      ss_low();
      check($sformatf("v%0d busy at start", v), 32'(busy), 32'd1);
      check($sformatf("v%0d tx_ready at start", v), 32'(tx_ready), 32'd1);
      xfer_bits(vecs[v].mo, 0, 32);
      ss_high();
      check($sformatf("v%0d master rx", v), m_rx, vecs[v].exp_miso);
      check($sformatf("v%0d rx_data", v), rx_data, vecs[v].exp_rx);
      check($sformatf("v%0d rx_pending", v), 32'(rx_pending), 32'(vecs[v].exp_pend));
      check($sformatf("v%0d rx_overrun", v), 32'(rx_overrun), 32'(vecs[v].exp_ovr));
      check($sformatf("v%0d busy at end", v), 32'(busy), 32'd0);
      if (vecs[v].ack) begin
        do_ack();
        check($sformatf("v%0d pending after ack", v), 32'(rx_pending), 32'd0);
        check($sformatf("v%0d overrun after ack", v), 32'(rx_overrun), 32'd0);
      end
    end

    // Aborted frame after 10 bits while a word is still pending.
    e0 = err_pulses;
    ss_low();
    xfer_bits(32'h0000_03FF, 0, 10);
    ss_high();
    check("abort frame_err pulses", 32'(err_pulses - e0), 32'd1);
    check("abort rx_pending", 32'(rx_pending), 32'd1);
    check("abort rx_data", rx_data, 32'h1234_5678);
    check("abort busy", 32'(busy), 32'd0);
    do_ack();
    ss_low();
    xfer_bits(32'hDEAD_BEEF, 0, 32);
    ss_high();
    check("after abort rx_data", rx_data, 32'hDEAD_BEEF);
    check("after abort rx_pending", 32'(rx_pending), 32'd1);
    do_ack();

    // tx_write in the middle of a frame is held for the following frame.
    ss_low();
    xfer_bits(32'h0BAD_F00D, 0, 16);
    write_tx(32'h0000_00FF);
    check("midwrite tx_ready", 32'(tx_ready), 32'd0);
    xfer_bits(32'h0BAD_F00D, 16, 16);
    ss_high();
    check("midwrite current frame", m_rx, 32'hF0F0_F0F0);
    check("midwrite tx_ready after frame", 32'(tx_ready), 32'd0);
    check("midwrite rx_data", rx_data, 32'h0BAD_F00D);
    ss_low();
    check("midwrite tx_ready next start", 32'(tx_ready), 32'd1);
    xfer_bits(32'h5555_AAAA, 0, 32);
    ss_high();
    check("midwrite next frame", m_rx, 32'h0000_00FF);
    check("midwrite next rx_data", rx_data, 32'h5555_AAAA);
    check("midwrite overrun", 32'(rx_overrun), 32'd1);

    // Reset at bit 16; the rest of that frame must be ignored.
    ss_low();
    xfer_bits(32'h1357_9BDF, 0, 16);
    rst_n = 1'b0;
    clk_wait(2);
    check_reset_values("midreset");
    rst_n = 1'b1;
    e0 = err_pulses;
    xfer_bits(32'h1357_9BDF, 16, 16);
    check("midreset busy while ss low", 32'(busy), 32'd0);
    ss_high();
    check("midreset no frame_err", 32'(err_pulses - e0), 32'd0);
    check("midreset rx_pending", 32'(rx_pending), 32'd0);
    check("midreset rx_data", rx_data, 32'h0);
    ss_low();
    xfer_bits(32'hCAFE_F00D, 0, 32);
    ss_high();
    check("post reset rx_data", rx_data, 32'hCAFE_F00D);
    check("post reset master rx", m_rx, 32'hF0F0_F0F0);
    check("post reset rx_pending", 32'(rx_pending), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave endpoint, single system clock. It pairs with the team's SPI master: SS active-low, 32-bit frames, LSB first. The master drives MOSI on SCLK falling edges and samples MISO on SCLK falling edges.
- SCLK, SS and MOSI are oversampled and edge-detected in the clk domain. No logic is clocked by sclk.
- On the controller side, a TX holding register feeds the outgoing frame. Each complete received word is presented with a pending flag and an overrun flag.

Parameters:
- DATA_W, 32, frame length in bits and width of the data registers.
- IDLE_WORD, 32'hF0F0F0F0, word shifted out when no TX word is loaded at frame start.
- SYNC_STAGES, 2, synchronizer depth on sclk, ss and mosi (minimum 2).

Ports:
- clk  input  1  system clock; sclk period must be at least 8 clk periods.
- rst  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  word for the next frame.
- tx_write  input  1  load tx_data into the holding register.
- tx_ready  output  1  holding register empty.
- rx_data  output  DATA_W  last complete received word.
- rx_pending  output  1  rx_data valid and not yet acknowledged.
- rx_ack  input  1  clears rx_pending.
- rx_overrun  output  1  sticky; a word completed while rx_pending was set.
- frame_err  output  1  one-cycle pulse; ss rose before DATA_W bits were received.
- busy  output  1  frame in progress.
- sclk  input  1  SPI clock from master.
- ss  input  1  slave select, active low.
- mosi  input  1  master out, slave in.
- miso  output  1  slave out, master in.

Behaviour:
- Reset values (rst low): tx_ready=1, rx_data=0, rx_pending=0, rx_overrun=0, frame_err=0, busy=0, miso=0, state IDLE, bit counter 0. Synchronizers reset to sclk=0, ss=1, mosi=0.
- Edge detection runs on the synchronized signals:
  - sclk rise: last=0, current=1. sclk fall: last=1, current=0.
  - ss fall / ss rise: same rule applied to the synchronized ss.
  - Each detect is a one-cycle strobe, SYNC_STAGES+1 clk after the pin edge.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - On ss fall: load the TX shift register from the holding register if it is full, then set tx_ready=1. If the holding register is empty, load IDLE_WORD.
  - In the same cycle: miso = shift register bit 0, bit counter = 0, busy = 1, go to SHIFT.
- SHIFT:
  - On sclk rise: shift the RX register right, inserting the synchronized mosi at MSB; bit counter +1.
  - On sclk fall: shift the TX register right; miso = new bit 0.
  - When the bit counter reaches DATA_W after an sclk rise, go to DONE.
  - On ss rise with bit counter < DATA_W: pulse frame_err, discard the RX register, leave rx_data unchanged, go to IDLE, busy = 0.
- DONE (single cycle):
  - rx_data = RX register.
  - If rx_pending is already 1, set rx_overrun=1; rx_data is overwritten with the newer word.
  - rx_pending = 1, then go to IDLE.
  - busy stays 1 until ss rise; ignore further sclk edges until then.
- Holding register:
  - tx_write loads it and sets tx_ready=0, in any state; a write while busy is held for the next frame.
  - A write while tx_ready=0 overwrites the held word.
  - If tx_write coincides with the frame-start load, the frame uses the previous content (or IDLE_WORD if empty); the new word stays held and tx_ready=0.
- rx_pending / rx_overrun:
  - rx_ack clears rx_pending and rx_overrun next cycle.
  - If rx_ack coincides with DONE, the set wins: rx_pending=1, rx_overrun=0.
- Reset mid-frame returns everything to reset values immediately. The remaining frame is ignored until the next ss fall.
- ss held low at reset release does not start a frame; a fall edge is required.

Test Plan:
- Load 32'hA5C3_0F81; master frame sending 32'h1234_5678 -> master receives 32'hA5C3_0F81. rx_data=32'h1234_5678 and rx_pending=1 at DONE; tx_ready=1 from frame start.
- Frame with no tx_write since reset -> master receives 32'hF0F0F0F0.
- Two frames without rx_ack (32'h1, then 32'h2) -> after second frame: rx_data=32'h2, rx_overrun=1. rx_ack -> both flags 0.
- ss deasserted after 10 bits -> one-cycle frame_err; rx_pending unchanged; next full frame of 32'hDEADBEEF is received correctly.
- tx_write of 32'h0000_00FF during an active frame -> current frame unchanged, next frame sends 32'h0000_00FF, tx_ready=0 until that frame starts.
- rst pulsed low at bit 16 -> all outputs at reset values; the following full frame of 32'hCAFE_F00D is received correctly.
